// File: rtl/lite16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lite16_pkg
// Description : Shared constants for the LITE-16 register bank and its
//               write-side arbitration logic.
// Revision    : 1.0 - initial release
// ============================================================================
package lite16_pkg;

    // Register bank geometry
    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int AW    = 3;

    // Writeback requester indices
    localparam int NREQ    = 3;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_IMM = 2;

    // Width of an index into n items, never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : lite16_pkg
`default_nettype wire

// File: rtl/reg_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : reg_addr_decoder
// Description : Register address to one-hot enable decoder. Addresses at or
//               beyond NREG decode to all-zero so the access is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_addr_decoder
    import lite16_pkg::*;
#(
    parameter int AW   = lite16_pkg::AW,
    parameter int NREG = lite16_pkg::NREG
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    // Each output bit compares against its own index; out-of-range
    // addresses match no bit and therefore produce zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            assign onehot[gi] = (addr == AW'(gi));
        end
    endgenerate

endmodule : reg_addr_decoder
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin write-port arbiter for the LITE-16 register bank
//               with locked burst support. Grants one writeback source per
//               cycle and drives registered one-hot enables and write data.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import lite16_pkg::*;
#(
    parameter int WIDTH = lite16_pkg::WIDTH,
    parameter int NREG  = lite16_pkg::NREG,
    parameter int NREQ  = lite16_pkg::NREQ,
    parameter int AW    = lite16_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREG-1:0]       reg_en,
    output logic [WIDTH-1:0]      reg_data,
    output logic                  busy
);

    localparam int PW = idx_width(NREQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic             r_locked;
    logic [NREG-1:0]  r_reg_en;
    logic [WIDTH-1:0] r_reg_data;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic [PW:0]      w_pick;
    logic             w_win_valid;
    logic [PW-1:0]    w_win_idx;
    logic [NREQ-1:0]  w_gnt;
    logic [AW-1:0]    w_win_addr;
    logic [WIDTH-1:0] w_win_data;
    logic [NREG-1:0]  w_dec_en;

    // First requester found scanning ptr, ptr+1, ... mod NREQ; {valid, index}.
    // The scan runs from the farthest offset down so the nearest one wins.
    function automatic logic [PW:0] f_rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NREQ;
            if (r[idx]) begin
                res = {1'b1, PW'(idx)};
            end
        end
        return res;
    endfunction

    // (k + 1) mod NREQ
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] k);
        return (k == PW'(NREQ - 1)) ? '0 : k + PW'(1);
    endfunction

    assign w_pick = f_rr_pick(req, r_ptr);

    // While locked only the owner may win; everyone else stays pending
    assign w_win_valid = r_locked ? req[r_owner] : w_pick[PW];
    assign w_win_idx   = r_locked ? r_owner      : w_pick[PW-1:0];

    // One-hot grant plus the winner's address and data
    always_comb begin
        w_gnt      = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == PW'(i)) begin
                w_gnt[i]   = w_win_valid;
                w_win_addr = addr[i*AW +: AW];
                w_win_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    reg_addr_decoder #(
        .AW   (AW),
        .NREG (NREG)
    ) u_addr_dec (
        .addr   (w_win_addr),
        .onehot (w_dec_en)
    );

    // Pointer, lock ownership and the registered write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_locked   <= 1'b0;
            r_reg_en   <= '0;
            r_reg_data <= '0;
        end else begin
            if (w_win_valid) begin
                r_reg_en   <= w_dec_en;
                r_reg_data <= w_win_data;
            end else begin
                r_reg_en   <= '0;
            end

            if (r_locked) begin
                // Burst ends once the owner stops requesting or drops lock;
                // a final unlocked write has already been granted above.
                if (!(req[r_owner] && lock[r_owner])) begin
                    r_locked <= 1'b0;
                    r_ptr    <= f_next(r_owner);
                end
            end else if (w_win_valid) begin
                if (lock[w_win_idx]) begin
                    r_owner  <= w_win_idx;
                    r_locked <= 1'b1;
                end else begin
                    r_ptr    <= f_next(w_win_idx);
                end
            end
        end
    end

    assign gnt      = rst ? w_gnt : '0;
    assign reg_en   = r_reg_en;
    assign reg_data = r_reg_data;
    assign busy     = r_locked;

endmodule : reg_write_arbiter
`default_nettype wire
